// File: rtl/pga_agc_controller_pkg.sv
// Shared types and constants for the PGA automatic gain controller.
package pga_agc_pkg;
  localparam int          GAIN_W    = 3;
  localparam logic [7:0]  CODE_BASE = 8'h88;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_REQ, ST_BUSY, ST_DONE, ST_SETTLE
  } state_t;

  function automatic logic [7:0] gain_code(input logic [GAIN_W-1:0] g);
    return CODE_BASE | {{(8-GAIN_W){1'b0}}, g};
  endfunction
endpackage

// File: rtl/pga_agc_controller_peak_window_detector.sv
// Windowed peak |sample| detector; count and running max stay at zero while run is low.
module peak_window_detector #(
  parameter int SAMPLE_W   = 12,
  parameter int WINDOW_LEN = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                valid,
  output logic                done,
  output logic [SAMPLE_W-1:0] peak
);
  localparam int                 CW   = $clog2(WINDOW_LEN);
  localparam logic [CW-1:0]       LAST = CW'(WINDOW_LEN - 1);
  localparam logic [SAMPLE_W-1:0] FS   = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] NEG  = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0] mag, max_q, max_nx;
  logic [CW-1:0]       cnt;

  // Most negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    if (sample == NEG)             mag = FS;
    else if (sample[SAMPLE_W-1])   mag = -sample;
    else                           mag = sample;
    max_nx = (mag > max_q) ? mag : max_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      max_q <= '0;
      peak  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!run) begin
        cnt   <= '0;
        max_q <= '0;
      end else if (valid) begin
        if (cnt == LAST) begin
          cnt   <= '0;
          max_q <= '0;
          peak  <= max_nx;
          done  <= 1'b1;
        end else begin
          cnt   <= cnt + 1'b1;
          max_q <= max_nx;
        end
      end
    end
  end
endmodule

// File: rtl/pga_agc_controller.sv
// AGC top: gain decisions, manual override and the set/ready write sequence to the PGA.
module pga_agc_controller
  import pga_agc_pkg::*;
#(
  parameter int SAMPLE_W   = 12,
  parameter int WINDOW_LEN = 1024,
  parameter int HI_THRESH  = 1536,
  parameter int LO_THRESH  = 512,
  parameter int GAIN_MAX   = 7,
  parameter int GAIN_INIT  = 3,
  parameter int SETTLE_CYC = 64,
  parameter int BUSY_TMO   = 4
) (
  input  logic                sck,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                sample_valid_i,
  input  logic                manual_i,
  input  logic [GAIN_W-1:0]   manual_gain_i,
  input  logic                pga_ready_i,
  output logic                pga_set_o,
  output logic [7:0]          pga_code_o,
  output logic [GAIN_W-1:0]   gain_o,
  output logic                gain_valid_o,
  output logic [SAMPLE_W-1:0] peak_o
);
  localparam int                  TW       = $clog2(BUSY_TMO + 1);
  localparam int                  SW       = $clog2(SETTLE_CYC + 1);
  localparam logic [TW-1:0]       LAST_TMO = TW'(BUSY_TMO - 1);
  localparam logic [SW-1:0]       LAST_SET = SW'(SETTLE_CYC - 1);
  localparam logic [GAIN_W-1:0]   GMAX     = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0]   GINIT    = GAIN_W'(GAIN_INIT);
  localparam logic [GAIN_W-1:0]   G1       = GAIN_W'(1);
  localparam logic [GAIN_W-1:0]   G2       = GAIN_W'(2);
  localparam logic [SAMPLE_W-1:0] FS       = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] HI       = SAMPLE_W'(HI_THRESH);
  localparam logic [SAMPLE_W-1:0] LO       = SAMPLE_W'(LO_THRESH);

  state_t              state_q, state_d;
  logic [GAIN_W-1:0]   target_q, req_tgt, agc_tgt, man_tgt;
  logic                req, set_d, run, win_done;
  logic [TW-1:0]       tmo_q;
  logic [SW-1:0]       settle_q;

  assign run          = (state_q == ST_IDLE) && enable_i && !manual_i;
  assign gain_valid_o = (state_q == ST_IDLE);

  peak_window_detector #(.SAMPLE_W(SAMPLE_W), .WINDOW_LEN(WINDOW_LEN)) u_peak (
    .clk   (sck),
    .rst   (rst),
    .run   (run),
    .sample(sample_i),
    .valid (sample_valid_i),
    .done  (win_done),
    .peak  (peak_o)
  );

  // Full-scale peak means clipping: back off two steps instead of one.
  always_comb begin
    agc_tgt = gain_o;
    if (peak_o == FS)      agc_tgt = (gain_o >= G2) ? gain_o - G2 : '0;
    else if (peak_o >= HI) agc_tgt = (gain_o != '0) ? gain_o - G1 : '0;
    else if (peak_o < LO)  agc_tgt = (gain_o < GMAX) ? gain_o + G1 : GMAX;
    man_tgt = (manual_gain_i > GMAX) ? GMAX : manual_gain_i;
  end

  always_ff @(posedge sck) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    req_tgt = target_q;
    set_d   = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_REQ;
      ST_IDLE: begin
        if (manual_i) begin
          if (man_tgt != gain_o) begin
            req     = 1'b1;
            req_tgt = man_tgt;
          end
        end else if (win_done && enable_i && agc_tgt != gain_o) begin
          req     = 1'b1;
          req_tgt = agc_tgt;
        end
        if (req) state_d = ST_REQ;
      end
      ST_REQ: if (pga_ready_i) begin
        set_d   = 1'b1;
        state_d = ST_BUSY;
      end
      // A ready that never drops means the strobe was missed; resend the same code.
      ST_BUSY: begin
        if (!pga_ready_i)          state_d = ST_DONE;
        else if (tmo_q == LAST_TMO) state_d = ST_REQ;
      end
      ST_DONE:   if (pga_ready_i) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_q == LAST_SET) state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      target_q   <= GINIT;
      pga_code_o <= gain_code(GINIT);
      gain_o     <= GINIT;
      pga_set_o  <= 1'b0;
      tmo_q      <= '0;
      settle_q   <= '0;
    end else begin
      pga_set_o <= set_d;
      if (req) begin
        target_q   <= req_tgt;
        pga_code_o <= gain_code(req_tgt);
      end
      if (state_q == ST_DONE && pga_ready_i) gain_o <= target_q;
      tmo_q    <= (state_q == ST_BUSY)   ? tmo_q + 1'b1    : '0;
      settle_q <= (state_q == ST_SETTLE) ? settle_q + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_pga_agc_controller.sv
// Bench for pga_agc_controller with a behavioural PGA responder and gain reference model.
module tb_pga_agc_controller;
  localparam int FS  = 2047;
  localparam int HI  = 1536;
  localparam int LO  = 512;
  localparam int GMX = 7;

  logic        sck = 1'b0;
  logic        rst;
  logic        enable_i, sample_valid_i, manual_i, pga_ready_i;
  logic [11:0] sample_i;
  logic [2:0]  manual_gain_i;
  logic        pga_set_o, gain_valid_o;
  logic [7:0]  pga_code_o;
  logic [2:0]  gain_o;
  logic [11:0] peak_o;

  int errors = 0;
  int checks = 0;
  int nwr    = 0;
  logic [7:0] last_code = 8'h00;
  logic       ignore = 1'b0;
  int         busy = 0;

  always #5 sck = ~sck;

  pga_agc_controller #(.WINDOW_LEN(16), .SETTLE_CYC(8)) dut (
    .sck(sck), .rst(rst), .enable_i(enable_i), .sample_i(sample_i),
    .sample_valid_i(sample_valid_i), .manual_i(manual_i), .manual_gain_i(manual_gain_i),
    .pga_ready_i(pga_ready_i), .pga_set_o(pga_set_o), .pga_code_o(pga_code_o),
    .gain_o(gain_o), .gain_valid_o(gain_valid_o), .peak_o(peak_o)
  );

  // PGA responder: ready drops for three cycles after each strobe unless told to ignore it.
  always @(posedge sck) begin
    if (rst) begin
      pga_ready_i <= 1'b1;
      busy        <= 0;
    end else if (pga_set_o && !ignore) begin
      pga_ready_i <= 1'b0;
      busy        <= 3;
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) pga_ready_i <= 1'b1;
    end
  end

  always @(posedge sck) begin
    if (!rst && pga_set_o) begin
      nwr       <= nwr + 1;
      last_code <= pga_code_o;
    end
  end

  function automatic int mag(input int s);
    if (s == -2048) return FS;
    return (s < 0) ? -s : s;
  endfunction

  function automatic int next_gain(input int g, input int pk);
    if (pk == FS) return (g >= 2) ? g - 2 : 0;
    if (pk >= HI) return (g > 0) ? g - 1 : 0;
    if (pk < LO)  return (g < GMX) ? g + 1 : GMX;
    return g;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!gain_valid_o && n < 200) begin
      @(negedge sck);
      n++;
    end
    chk(nm, int'(gain_valid_o), 1);
  endtask

  task automatic wait_strobe(input string nm);
    int n = 0;
    while (!pga_set_o && n < 20) begin
      @(negedge sck);
      n++;
    end
    chk(nm, int'(pga_set_o), 1);
  endtask

  task automatic send_win(input int s[16], input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          sample_i       = 12'($urandom);
          sample_valid_i = 1'b0;
          @(negedge sck);
        end
      end
      sample_i       = 12'(s[i]);
      sample_valid_i = 1'b1;
      @(negedge sck);
    end
    sample_valid_i = 1'b0;
  endtask

  task automatic run_window(input int s[16], input bit gaps, input int epk, input int eg,
                            input int ewr, input int ecode, input string tag);
    int n0 = nwr;
    send_win(s, gaps);
    chk({tag, " peak"}, int'(peak_o), epk);
    repeat (2) @(negedge sck);
    wait_idle({tag, " idle"});
    chk({tag, " gain"}, int'(gain_o), eg);
    chk({tag, " writes"}, nwr - n0, ewr);
    if (ewr != 0) chk({tag, " code"}, int'(last_code), ecode);
  endtask

  typedef struct {
    int fill;
    int spec;
    int peak;
    int gain;
    int wr;
    int code;
  } row_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl[19];
    int   s[16];
    int   n0, g, k, t1, t2, seen;

    tbl[0]  = '{0, -2048, 2047, 1, 1, 'h89};
    tbl[1]  = '{0, -2048, 2047, 0, 1, 'h88};
    tbl[2]  = '{1800, 1800, 1800, 0, 0, 'h88};
    tbl[3]  = '{100, 100, 100, 1, 1, 'h89};
    tbl[4]  = '{600, 600, 600, 1, 0, 'h89};
    tbl[5]  = '{0, -1536, 1536, 0, 1, 'h88};
    tbl[6]  = '{511, 511, 511, 1, 1, 'h89};
    tbl[7]  = '{512, 512, 512, 1, 0, 'h89};
    tbl[8]  = '{1535, -1535, 1535, 1, 0, 'h89};
    tbl[9]  = '{100, 100, 100, 2, 1, 'h8A};
    tbl[10] = '{100, 100, 100, 3, 1, 'h8B};
    tbl[11] = '{100, 100, 100, 4, 1, 'h8C};
    tbl[12] = '{100, 100, 100, 5, 1, 'h8D};
    tbl[13] = '{100, 100, 100, 6, 1, 'h8E};
    tbl[14] = '{100, 100, 100, 7, 1, 'h8F};
    tbl[15] = '{100, 100, 100, 7, 0, 'h8F};
    tbl[16] = '{1800, 1800, 1800, 6, 1, 'h8E};
    tbl[17] = '{100, 100, 100, 7, 1, 'h8F};
    tbl[18] = '{-2047, -2047, 2047, 5, 1, 'h8D};

    rst = 1'b1; enable_i = 1'b1; manual_i = 1'b0; manual_gain_i = 3'd0;
    sample_i = '0; sample_valid_i = 1'b0;
    repeat (3) @(negedge sck);
    chk("rst set", int'(pga_set_o), 0);
    chk("rst code", int'(pga_code_o), 'h8B);
    chk("rst gain", int'(gain_o), 3);
    chk("rst gain_valid", int'(gain_valid_o), 0);
    chk("rst peak", int'(peak_o), 0);

    // Power-up programming of the initial gain.
    n0  = nwr;
    rst = 1'b0;
    wait_strobe("init strobe");
    chk("init code", int'(pga_code_o), 'h8B);
    wait_idle("init idle");
    chk("init gain", int'(gain_o), 3);
    chk("init writes", nwr - n0, 1);

    for (int r = 0; r < 19; r++) begin
      for (int i = 0; i < 16; i++) s[i] = (i == 7) ? tbl[r].spec : tbl[r].fill;
      run_window(s, 1'b0, tbl[r].peak, tbl[r].gain, tbl[r].wr, tbl[r].code,
                 $sformatf("row%0d", r));
    end

    // Manual request arriving mid-write is deferred until the controller is idle again.
    n0 = nwr;
    for (int i = 0; i < 16; i++) s[i] = 1800;
    send_win(s, 1'b0);
    chk("man agc peak", int'(peak_o), 1800);
    wait_strobe("man agc strobe");
    manual_i = 1'b1; manual_gain_i = 3'd5;
    @(negedge sck);
    wait_idle("man first idle");
    chk("man no restrobe", nwr - n0, 1);
    chk("man agc gain", int'(gain_o), 4);
    chk("man agc code", int'(last_code), 'h8C);
    repeat (60) @(negedge sck);
    chk("man writes", nwr - n0, 2);
    chk("man code", int'(last_code), 'h8D);
    chk("man gain", int'(gain_o), 5);
    chk("man gain_valid", int'(gain_valid_o), 1);
    repeat (40) @(negedge sck);
    chk("man hold no write", nwr - n0, 2);

    // Missed strobe: ready never drops, so the same code is resent after the timeout.
    ignore = 1'b1; manual_gain_i = 3'd2;
    seen = 0; k = 0; t1 = 0; t2 = 0;
    while (seen < 2 && k < 40) begin
      @(negedge sck);
      k++;
      if (pga_set_o) begin
        seen++;
        chk($sformatf("retry code%0d", seen), int'(pga_code_o), 'h8A);
        if (seen == 1) t1 = k; else t2 = k;
      end
    end
    ignore = 1'b0;
    chk("retry strobes", seen, 2);
    chk("retry gap", t2 - t1, 5);
    chk("retry gain held", int'(gain_o), 5);
    k = 0;
    while (pga_ready_i && k < 10) begin
      @(negedge sck);
      k++;
    end
    chk("retry ready low", int'(pga_ready_i), 0);
    @(negedge sck);
    rst = 1'b1; manual_i = 1'b0;
    @(negedge sck);
    chk("midrst set", int'(pga_set_o), 0);
    chk("midrst code", int'(pga_code_o), 'h8B);
    chk("midrst gain", int'(gain_o), 3);
    chk("midrst gain_valid", int'(gain_valid_o), 0);
    chk("midrst peak", int'(peak_o), 0);
    @(negedge sck);
    n0  = nwr;
    rst = 1'b0;
    repeat (2) @(negedge sck);
    wait_idle("reinit idle");
    chk("reinit writes", nwr - n0, 1);
    chk("reinit code", int'(last_code), 'h8B);

    // Random windows against the reference model.
    g = 3;
    for (int w = 0; w < 10; w++) begin
      int amp, sel, pk, ng;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: amp = 300;
        1: amp = 600;
        2: amp = 1200;
        default: amp = 2047;
      endcase
      for (int i = 0; i < 16; i++) s[i] = int'($urandom_range(0, 2 * amp)) - amp;
      if (sel == 4) s[$urandom_range(0, 15)] = -2048;
      pk = 0;
      for (int i = 0; i < 16; i++) if (mag(s[i]) > pk) pk = mag(s[i]);
      ng = next_gain(g, pk);
      run_window(s, 1'b1, pk, ng, (ng != g) ? 1 : 0, 'h88 | ng, $sformatf("rnd%0d", w));
      g = ng;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
